// File: rtl/seq_scan_ctrl.sv
// Serial pattern scanner: shifts each accepted word MSB first and counts overlapping PAT hits.
// Define SEQ_CARRY_EN to keep the bit history across words so matches may span word boundaries.
module seq_scan_ctrl #(
    parameter int             WORD_W = 16,
    parameter int             PAT_W  = 3,
    parameter logic [PAT_W-1:0] PAT  = 3'b101
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WORD_W-1:0]            in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(WORD_W+1)-1:0]  out_count,
    output logic                         busy
);

    localparam int CW = $clog2(WORD_W + 1);
    localparam int FW = $clog2(PAT_W + 1);

`ifdef SEQ_CARRY_EN
    localparam bit CARRY = 1'b1;
`else
    localparam bit CARRY = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [WORD_W-1:0]  r_word;
    logic [PAT_W-1:0]   r_hist;
    logic [FW-1:0]      r_fill;
    logic [CW-1:0]      r_bitcnt;
    logic [CW-1:0]      r_match;

    logic               w_accept;
    logic               w_bit;
    logic [PAT_W-1:0]   w_hist_nxt;
    logic [FW-1:0]      w_fill_nxt;
    logic               w_hit;
    logic               w_last;

    assign w_accept   = in_valid && in_ready;
    assign w_bit      = r_word[WORD_W-1];
    assign w_hist_nxt = {r_hist[PAT_W-2:0], w_bit};
    // Fill count saturates at PAT_W: the window is then fully populated.
    assign w_fill_nxt = (r_fill == FW'(PAT_W)) ? r_fill : r_fill + FW'(1);
    assign w_hit      = (w_hist_nxt == PAT) && (w_fill_nxt == FW'(PAT_W));
    assign w_last     = (r_bitcnt == CW'(WORD_W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept)  w_next = SHIFT;
            SHIFT:   if (w_last)    w_next = REPORT;
            REPORT:  if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        busy      = (r_state != IDLE);
        out_valid = (r_state == REPORT);
        out_count = (r_state == REPORT) ? r_match : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word   <= '0;
            r_hist   <= '0;
            r_fill   <= '0;
            r_bitcnt <= '0;
            r_match  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_word   <= in_data;
                        r_bitcnt <= '0;
                        r_match  <= '0;
                        if (!CARRY) begin
                            r_hist <= '0;
                            r_fill <= '0;
                        end
                    end
                end
                SHIFT: begin
                    r_word   <= r_word << 1;
                    r_hist   <= w_hist_nxt;
                    r_fill   <= w_fill_nxt;
                    r_bitcnt <= r_bitcnt + CW'(1);
                    if (w_hit) r_match <= r_match + CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Bench for seq_scan_ctrl (WORD_W=8, PAT_W=3, PAT=101): cycle model plus directed scenarios.
// Literal expectations follow the SEQ_CARRY_EN setting of the build.
module tb_seq_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_count;
    logic       busy;

    seq_scan_ctrl #(.WORD_W(8), .PAT_W(3), .PAT(3'b101)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Matches of 101 whose last bit lies inside the word, given prior history bits.
    function automatic int count_word(input logic [7:0] w, input logic [1:0] tail, input int tlen);
        int s[$];
        int n = 0;
        for (int i = 0; i < tlen; i++) s.push_back(int'(tail[tlen-1-i]));
        for (int i = 7; i >= 0; i--) s.push_back(int'(w[i]));
        for (int i = 2; i < s.size(); i++)
            if (s[i-2] == 1 && s[i-1] == 0 && s[i] == 1) n++;
        return n;
    endfunction

    bit         m_init = 0;
    bit         m_idle = 1;
    bit         m_rep  = 0;
    int         m_left = 0;
    int         m_exp  = 0;
    logic [1:0] m_tail = 2'b00;
    int         m_tlen = 0;
    int         dut_res[$];

    always @(posedge clk) begin
        if (rst) begin
            m_init = 1;
            m_idle = 1;
            m_rep  = 0;
            m_tlen = 0;
        end else if (m_init) begin
            if (m_idle) begin
                if (in_valid) begin
                    m_exp  = count_word(in_data, m_tail, m_tlen);
`ifdef SEQ_CARRY_EN
                    m_tail = in_data[1:0];
                    m_tlen = 2;
`else
                    m_tlen = 0;
`endif
                    m_idle = 0;
                    m_left = 8;
                end
            end else if (!m_rep) begin
                m_left--;
                if (m_left == 0) m_rep = 1;
            end else if (out_ready) begin
                m_rep  = 0;
                m_idle = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("in_ready", 32'(in_ready), 32'(m_idle));
            chk("busy", 32'(busy), 32'(!m_idle));
            chk("out_valid", 32'(out_valid), 32'(m_rep));
            chk("out_count", 32'(out_count), m_rep ? m_exp : 0);
            if (out_valid && out_ready && !rst) dut_res.push_back(int'(out_count));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] w, input int hold, output int lat);
        int n;
        in_data   = w;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 40) begin
                chk("accept_timeout", 1, 0);
                break;
            end
        end
        tick();
        in_valid = 1'b0;
        in_data  = ~w;
        lat = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
            chk("scan_in_ready", 32'(in_ready), 0);
            if (lat > 30) begin
                chk("result_timeout", 1, 0);
                break;
            end
        end
        if (hold > 0) begin
            repeat (hold) tick();
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_in_ready", 32'(in_ready), 0);
            out_ready = 1'b1;
            tick();
            chk("idle_after_hs", 32'(in_ready), 1);
        end else begin
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int nres;
        int acc;
        int idx;
        int guard;
        logic [7:0] words [4];
        words[0] = 8'hA5;
        words[1] = 8'h5A;
        words[2] = 8'h3C;
        words[3] = 8'hE1;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_count", 32'(out_count), 0);

        send(8'b10101010, 0, lat);
        chk("s1_latency", lat, 9);
        chk("s1_count", dut_res[$], 3);

        send(8'h00, 0, lat);
        chk("s2_zero_count", dut_res[$], 0);
        send(8'hFF, 0, lat);
        chk("s2_ones_count", dut_res[$], 0);

        send(8'b10110101, 5, lat);
        chk("s3_count", dut_res[$], 3);

        in_data  = 8'b10101010;
        in_valid = 1'b1;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!in_ready && guard < 40);
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        rst  = 1'b1;
        nres = dut_res.size();
        tick();
        rst = 1'b0;
        chk("s4_in_ready", 32'(in_ready), 1);
        chk("s4_busy", 32'(busy), 0);
        chk("s4_out_valid", 32'(out_valid), 0);
        repeat (12) tick();
        chk("s4_no_result", dut_res.size(), nres);
        send(8'b00000101, 0, lat);
        chk("s4_count", dut_res[$], 1);

        send(8'b00000010, 0, lat);
        chk("s5_first", dut_res[$], 0);
        send(8'b10000000, 0, lat);
`ifdef SEQ_CARRY_EN
        chk("s5_second", dut_res[$], 1);
`else
        chk("s5_second", dut_res[$], 0);
`endif

        nres      = dut_res.size();
        acc       = 0;
        idx       = 0;
        guard     = 0;
        out_ready = 1'b1;
        in_data   = words[0];
        in_valid  = 1'b1;
        while (idx < 4 && guard < 200) begin
            @(negedge clk);
            guard++;
            if (in_ready) begin
                acc++;
                tick();
                idx++;
                if (idx == 4) in_valid = 1'b0;
                else in_data = words[idx];
            end
        end
        chk("s6_accepts", acc, 4);
        guard = 0;
        while (dut_res.size() < nres + 4 && guard < 40) begin
            tick();
            guard++;
        end
        repeat (3) tick();
        chk("s6_results", dut_res.size() - nres, 4);
        chk("s6_span", guard, 9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_scan_ctrl.md
SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 The block SHALL have parameter WORD_W, default 16, meaning bits per scanned word; legal range 4..32.
REQ-002 The block SHALL have parameter PAT_W, default 3, meaning pattern length in bits; legal range 2..WORD_W.
REQ-003 The block SHALL have parameter PAT, default 3'b101, meaning the target bit pattern, compared with the oldest bit at PAT[PAT_W-1].
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the producer offers in_data.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-008 The block SHALL have port in_data, input, WORD_W bits: the word to scan, shifted MSB first.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the result is available.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 The block SHALL have port out_count, output, $clog2(WORD_W+1) bits: the number of pattern matches in the word.
REQ-012 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-013 The controller SHALL be an FSM with states IDLE, SHIFT and REPORT.
REQ-014 In IDLE, in_ready SHALL be 1; in SHIFT and REPORT, in_ready SHALL be 0.
REQ-015 The block SHALL accept a word when in_valid && in_ready: it latches in_data, clears the bit counter and the match counter, and goes to SHIFT.
REQ-016 In SHIFT, the block SHALL feed one bit per cycle, MSB first, into a PAT_W-bit history register, for exactly WORD_W cycles.
REQ-017 A match SHALL count when the updated history equals PAT and at least PAT_W valid bits are in history.
- Matches overlap: 101 followed by 01 gives 2 matches.
REQ-018 After the WORD_W-th bit, the FSM SHALL go to REPORT.
- out_valid SHALL assert in the cycle WORD_W+1 after the accept edge.
REQ-019 In REPORT, out_valid SHALL be 1 and out_count SHALL hold stable until out_valid && out_ready; the FSM then returns to IDLE.
REQ-020 out_count SHALL never wrap: its maximum value is WORD_W-PAT_W+1.
REQ-021 in_ready SHALL NOT depend combinationally on out_ready.
- A new word is accepted no earlier than the cycle after the result handshake.
REQ-022 in_valid SHALL be ignored outside IDLE; in_data is sampled only on accept.
REQ-023 out_count SHALL read 0 whenever out_valid is 0.

Reset
REQ-024 When rst=1 at a clock edge, the block SHALL:
- go to IDLE;
- set in_ready=1, out_valid=0, busy=0, out_count=0;
- clear the history register, the valid-fill count, the bit counter and the match counter.
REQ-025 Reset SHALL take priority over every handshake.
- Reset mid-SHIFT or mid-REPORT discards the word and its result; no out_valid follows.

Configuration
REQ-026 Macro SEQ_CARRY_EN SHALL control history carry between words.
- Defined: the history register and its valid-fill count persist across word boundaries, so a match may span the last bits of one word and the first bits of the next; it counts in the later word. Only reset clears the history.
- Undefined: history and fill count clear on every accept; no cross-word match.

Verification
REQ-027 All scenarios below SHALL use WORD_W=8, PAT_W=3, PAT=3'b101.
REQ-028 Scenario 1: accept in_data=8'b10101010 with out_ready=1 -> out_valid 9 cycles after accept, out_count=3.
REQ-029 Scenario 2: in_data=8'h00, then 8'hFF -> out_count=0 for each; in_ready=0 for the whole of each scan.
REQ-030 Scenario 3: in_data=8'b10110101, then hold out_ready=0 for 5 cycles -> out_valid stays 1 and out_count=3 stays stable; in_ready=0; return to IDLE one cycle after out_ready=1.
REQ-031 Scenario 4: assert rst on the 4th SHIFT cycle of 8'b10101010 -> next cycle in_ready=1, busy=0, out_valid=0; a following word 8'b00000101 gives out_count=1.
REQ-032 Scenario 5: in_data=8'b00000010, then 8'b10000000 -> second out_count=1 with SEQ_CARRY_EN defined, 0 without; first out_count=0 in both builds.
REQ-033 Scenario 6: drive in_valid=1 continuously with distinct words -> each word accepted exactly once, one result per word, in order.
